fb_paint_sink: RTL and testbench

//  Receiving end of the paint pixel-write interface (paint, x, y, px_data) driven by the paint controller.

---
 rtl/fb_pkg.sv | 17 +
 rtl/paint_wr_fifo.sv | 48 ++++
 rtl/fb_paint_sink.sv | 125 ++++++++++++
 tb/tb_fb_paint_sink.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer paint sink and its write queue.
package fb_pkg;
  localparam int FB_XW = 6;
  localparam int FB_YW = 6;
  localparam int FB_DW = 8;

  typedef logic [FB_XW+FB_YW-1:0] fb_addr_t;
  typedef logic [FB_DW-1:0]       px_t;

  typedef struct packed {
    logic [FB_YW-1:0] y;
    logic [FB_XW-1:0] x;
    px_t              data;
  } fb_wr_t;

  typedef enum logic {ST_IDLE, ST_CLEAR} fb_state_t;
endpackage

// File: rtl/paint_wr_fifo.sv
// Synchronous FIFO of pending pixel writes; pointers wrap modulo DEPTH (power of two).
module paint_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fb_wr_t                       wr_data,
  input  logic                         pop,
  output fb_wr_t                       rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fb_wr_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // NOTE: the storage array has no reset; only pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/fb_paint_sink.sv
// Paint write sink: queues pixel writes and arbitrates one framebuffer RAM access per cycle.
// Define FB_CLEAR_EN to build the full-frame clear engine (CLEAR state, clear_busy).
module fb_paint_sink
  import fb_pkg::*;
#(
  parameter int        XW          = FB_XW,
  parameter int        YW          = FB_YW,
  parameter int        DW          = FB_DW,
  parameter int        FIFO_DEPTH  = 4,
  parameter logic [DW-1:0] CLEAR_COLOR = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             paint,
  input  logic [XW-1:0]    in_x,
  input  logic [YW-1:0]    in_y,
  input  logic [DW-1:0]    px_data,
  output logic             full,
  output logic             overflow,
  input  logic             disp_rd,
  input  logic [XW-1:0]    disp_x,
  input  logic [YW-1:0]    disp_y,
  output logic [DW-1:0]    disp_data,
  output logic             disp_valid,
  output logic [XW+YW-1:0] mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_we,
  output logic             mem_re,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             clear,
  output logic             clear_busy
);
  localparam int AW = XW + YW;
  localparam logic [AW-1:0] CLR_LAST = '1;

  fb_state_t      state, state_nxt;
  logic [AW-1:0]  clr_cnt, clr_cnt_nxt;
  logic           push, pop, fifo_full, fifo_empty, clear_req;
  fb_wr_t         head;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_unused;

`ifdef FB_CLEAR_EN
  assign clear_req  = clear;
  assign clear_busy = (state == ST_CLEAR);
`else
  logic clear_unused;
  assign clear_unused = clear;
  assign clear_req    = 1'b0;
  assign clear_busy   = 1'b0;
`endif

  // A pop frees a slot on the same edge, so a full FIFO still accepts a write that cycle.
  assign push = paint && (!fifo_full || pop);
  assign full = fifo_full;

  paint_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ('{y: in_y, x: in_x, data: px_data}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    pop         = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    if (disp_rd) begin
      mem_re   = 1'b1;
      mem_addr = {disp_y, disp_x};
    end

    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end else if (!disp_rd && !fifo_empty) begin
          pop       = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {head.y, head.x};
          mem_wdata = head.data;
        end
      end
      ST_CLEAR: begin
        // Display reads stall the sweep; the counter only advances on issued writes.
        if (!disp_rd) begin
          mem_we      = 1'b1;
          mem_addr    = clr_cnt;
          mem_wdata   = CLEAR_COLOR;
          clr_cnt_nxt = clr_cnt + AW'(1);
          if (clr_cnt == CLR_LAST) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      overflow   <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      disp_valid <= disp_rd;
      if (paint && !push) overflow <= 1'b1;
    end
  end

  assign disp_data = disp_valid ? mem_rdata : '0;
endmodule

// File: tb/tb_fb_paint_sink.sv
// Randomized bench for fb_paint_sink against a queue-based model with a shadow framebuffer.
module tb_fb_paint_sink;
  import fb_pkg::*;

`ifdef FB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  localparam logic [7:0] CLR_COLOR = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        paint, disp_rd, clear;
  logic [5:0]  in_x, in_y, disp_x, disp_y;
  logic [7:0]  px_data, disp_data, mem_wdata, mem_rdata;
  logic        full, overflow, disp_valid, mem_we, mem_re, clear_busy;
  logic [11:0] mem_addr;

  always #5 clk = ~clk;

  fb_paint_sink dut (
    .clk(clk), .rst(rst), .paint(paint), .in_x(in_x), .in_y(in_y), .px_data(px_data),
    .full(full), .overflow(overflow), .disp_rd(disp_rd), .disp_x(disp_x), .disp_y(disp_y),
    .disp_data(disp_data), .disp_valid(disp_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .clear(clear), .clear_busy(clear_busy)
  );

  // Environment RAM: unwritten locations read back a fixed pattern of their address.
  logic [7:0] ram   [4096];
  bit         wrote [4096];
  function automatic logic [7:0] seed(input logic [11:0] a);
    return a[7:0] ^ {2'b10, a[11:6]};
  endfunction
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]   <= mem_wdata;
      wrote[mem_addr] <= 1'b1;
    end
    if (mem_re) mem_rdata <= wrote[mem_addr] ? ram[mem_addr] : seed(mem_addr);
  end

  // Reference model
  fb_wr_t      mq[$];
  logic [7:0]  mfb [4096];
  bit          m_ovf, m_clearing, m_valid;
  logic [11:0] m_cnt;
  logic [7:0]  m_rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_clearing = 0; m_valid = 0; m_cnt = '0; m_rd_data = '0;
  endtask

  // Drive one cycle (called at a negedge), check outputs against the model, advance the model.
  task automatic step(input bit p, input bit [5:0] x, input bit [5:0] y, input bit [7:0] d,
                      input bit dr, input bit [5:0] dx, input bit [5:0] dy, input bit clr);
    bit          we_e, pop_e;
    bit [11:0]   a_e;
    bit [7:0]    wd_e;
    paint = p; in_x = x; in_y = y; px_data = d;
    disp_rd = dr; disp_x = dx; disp_y = dy; clear = clr;
    #1;
    check("full", full, mq.size() == 4);
    check("overflow", overflow, m_ovf);
    check("disp_valid", disp_valid, m_valid);
    if (m_valid) check("disp_data", disp_data, m_rd_data);
    check("clear_busy", clear_busy, m_clearing);

    we_e = 0; pop_e = 0; a_e = '0; wd_e = '0;
    if (dr) a_e = {dy, dx};
    else if (m_clearing) begin
      we_e = 1; a_e = m_cnt; wd_e = CLR_COLOR;
    end else if (!(CLR_EN && clr) && mq.size() > 0) begin
      we_e = 1; pop_e = 1; a_e = {mq[0].y, mq[0].x}; wd_e = mq[0].data;
    end
    check("mem_re", mem_re, dr);
    check("mem_we", mem_we, we_e);
    if (dr || we_e) check("mem_addr", mem_addr, a_e);
    if (we_e) check("mem_wdata", mem_wdata, wd_e);

    m_valid = dr;
    if (dr) m_rd_data = mfb[{dy, dx}];
    if (we_e) mfb[a_e] = wd_e;
    if (pop_e) void'(mq.pop_front());
    if (p) begin
      if (mq.size() < 4) mq.push_back('{y: y, x: x, data: d});
      else m_ovf = 1;
    end
    if (m_clearing) begin
      if (!dr) begin
        if (m_cnt == 12'hFFF) m_clearing = 0;
        m_cnt = m_cnt + 12'd1;
      end
    end else if (CLR_EN && clr) begin
      m_clearing = 1;
      m_cnt = '0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_re"}, mem_re, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_valid"}, disp_valid, 0);
    check({tag, "_data"}, disp_data, 0);
    check({tag, "_busy"}, clear_busy, 0);
  endtask

  task automatic do_reset();
    paint = 0; disp_rd = 0; clear = 0;
    #2 rst = 1;
    #1 check_all_zero("rst");
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1; paint = 0; disp_rd = 0; clear = 0;
    in_x = 0; in_y = 0; px_data = 0; disp_x = 0; disp_y = 0;
    for (int i = 0; i < 4096; i++) mfb[i] = seed(12'(i));
    model_reset();
    #1 check_all_zero("init");
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // Single uncontended paint lands on the RAM one cycle after the push edge.
    step(1, 6'd3, 6'd5, 8'hA7, 0, 0, 0, 0);
    #1;
    check("single_we", mem_we, 1);
    check("single_addr", mem_addr, 12'h143);
    check("single_wdata", mem_wdata, 8'hA7);
    idle();
    idle();

    // Fill under display contention, then push and pop together while full.
    for (int i = 0; i < 4; i++) step(1, 6'(i), 6'(i + 1), 8'(8'h20 + i), 1, 6'(i), 0, 0);
    #1 check("fill_full", full, 1);
    step(1, 6'd9, 6'd9, 8'h99, 0, 0, 0, 0);
    #1;
    check("pp_full", full, 1);
    check("pp_ovf", overflow, 0);
    repeat (6) idle();

    // Four paints held off by disp_rd, a fifth one is dropped.
    for (int i = 0; i < 4; i++) step(1, 6'(10 + i), 6'(i), 8'(8'h10 + i), 1, 6'(i), 6'(i), 0);
    #1 check("q4_full", full, 1);
    step(1, 6'd20, 6'd20, 8'hEE, 1, 0, 0, 0);
    #1 check("q5_ovf", overflow, 1);
    repeat (6) idle();

    // Corner read at {63,63}.
    step(1, 6'd63, 6'd63, 8'h5C, 0, 0, 0, 0);
    idle();
    disp_rd = 1; disp_x = 6'd63; disp_y = 6'd63;
    #1;
    check("rd_re", mem_re, 1);
    check("rd_addr", mem_addr, 12'hFFF);
    step(0, 0, 0, 0, 1, 6'd63, 6'd63, 0);
    #1;
    check("rd_valid", disp_valid, 1);
    check("rd_data", disp_data, 8'h5C);
    idle();

    do_reset();
    idle();

`ifdef FB_CLEAR_EN
    // Full clear with one queued paint, a stall read and an ignored re-trigger.
    step(1, 6'd7, 6'd9, 8'h3C, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5000; k++) begin
      if (!m_clearing) break;
      step(0, 0, 0, 0, k == 100, 6'd1, 6'd2, k == 200);
    end
    #1 check("clear_done", clear_busy, 0);
    idle();
    idle();
    check("clear_paint_kept", ram[{6'd9, 6'd7}], 8'h3C);
    check("clear_cell0", ram[12'h000], CLR_COLOR);
    check("clear_cellfff", ram[12'hFFF], CLR_COLOR);
`endif

    // Reset with writes queued (and a clear running when built in).
    for (int i = 0; i < 3; i++) step(1, 6'(i), 6'(i), 8'(8'h70 + i), 1, 0, 0, 0);
`ifdef FB_CLEAR_EN
    step(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (50) idle();
`endif
    do_reset();
    repeat (5) idle();

    // Randomized traffic over a small address window to provoke same-address writes.
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 1) == 1, 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
           8'($urandom), $urandom_range(0, 3) == 0, 6'($urandom_range(0, 3)),
           6'($urandom_range(0, 3)), !CLR_EN && ($urandom_range(0, 7) == 0));
    end
    repeat (6) idle();
    for (int a = 0; a < 16; a++) step(0, 0, 0, 0, 1, 6'(a % 4), 6'(a / 4), 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
